// File: rtl/strokie_pkg.sv
// Shared types and encodings for the strokie result sink: entry layout,
// display FSM states, LED byte-index codes and precision-mode encodings.
package strokie_pkg;

  localparam int RESULT_W = 32;
  localparam int FLAGS_W  = 5;
  localparam int ENTRY_W  = 1 + FLAGS_W + RESULT_W;

  localparam logic FP_HALF   = 1'b0;
  localparam logic FP_SINGLE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW,
    ST_HOLD
  } disp_state_e;

  typedef enum logic [2:0] {
    IDX_B3    = 3'd0,
    IDX_B2    = 3'd1,
    IDX_B1    = 3'd2,
    IDX_B0    = 3'd3,
    IDX_FLAGS = 3'd4,
    IDX_NONE  = 3'd7
  } show_idx_e;

  typedef struct packed {
    logic                mode_fp;
    logic [FLAGS_W-1:0]  flags;
    logic [RESULT_W-1:0] result;
  } entry_t;

  // Half-precision results live in RESULT[15:8]/[7:0], so they skip the top two bytes.
  function automatic show_idx_e first_idx(input logic mode_fp);
    return (mode_fp == FP_SINGLE) ? IDX_B3 : IDX_B1;
  endfunction

  function automatic logic [7:0] select_byte(input entry_t e, input show_idx_e idx);
    logic [7:0] b;
    b = '0;
    case (idx)
      IDX_B3:    b = e.result[31:24];
      IDX_B2:    b = e.result[23:16];
      IDX_B1:    b = e.result[15:8];
      IDX_B0:    b = e.result[7:0];
      IDX_FLAGS: b = {{(8-FLAGS_W){1'b0}}, e.flags};
      default:   b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/strokie_result_sink_if.sv
// Result-side bus of the strokie sink: FP unit result/flags in, LED display
// and FIFO status out. The FP unit (or bench) is the master, the sink the slave.
interface strokie_result_sink_if #(
  parameter int CNT_W = 8
);
  import strokie_pkg::*;

  logic [RESULT_W-1:0] RESULT;
  logic                VALID_OUT;
  logic [FLAGS_W-1:0]  FLAGS;
  logic                MODE_FP;
  logic                CLEAR;

  logic [7:0]          LEDS;
  logic [2:0]          SHOW_IDX;
  logic                EMPTY;
  logic                FULL;
  logic                OVERFLOW;
  logic [CNT_W-1:0]    CAPTURED;

  modport master (
    output RESULT, VALID_OUT, FLAGS, MODE_FP, CLEAR,
    input  LEDS, SHOW_IDX, EMPTY, FULL, OVERFLOW, CAPTURED
  );

  modport slave (
    input  RESULT, VALID_OUT, FLAGS, MODE_FP, CLEAR,
    output LEDS, SHOW_IDX, EMPTY, FULL, OVERFLOW, CAPTURED
  );

endinterface

// File: rtl/strokie_sync_fifo.sv
// Single-clock FIFO, power-of-two depth. A push while full is accepted only
// when a pop happens in the same cycle; push_ok_o reports acceptance.
module strokie_sync_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             push_ok_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == DEPTH_CNT);
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign push_ok_o = do_push;
  assign data_o    = mem_q[rd_ptr_q];

  // NOTE: storage array has no reset; only pointers and count define validity,
  // and leaving it unreset lets it map onto plain RAM/LUT storage.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/strokie_result_sink.sv
// Captures strokie FP results on VALID_OUT rising edges into a FIFO and replays
// each entry byte-by-byte on the LEDs, holding every byte for DWELL cycles.
module strokie_result_sink #(
  parameter int DEPTH = 4,
  parameter int DWELL = 50_000_000,
  parameter int CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  strokie_result_sink_if.slave bus
);
  import strokie_pkg::*;

  localparam int DCNT_W = $clog2(DWELL + 1);
  localparam logic [DCNT_W-1:0] DWELL_LAST = DCNT_W'(DWELL - 1);

  // Capture path
  logic   valid_q;
  logic   capture;
  entry_t push_entry;
  entry_t head;
  logic   fifo_pop, fifo_push_ok, fifo_full, fifo_empty;

  assign capture    = bus.VALID_OUT && !valid_q;
  assign push_entry = '{mode_fp: bus.MODE_FP, flags: bus.FLAGS, result: bus.RESULT};

  strokie_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .push_i    (capture),
    .data_i    (push_entry),
    .pop_i     (fifo_pop),
    .data_o    (head),
    .push_ok_o (fifo_push_ok),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Status counters
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] captured_q, captured_d;

  always_comb begin
    overflow_d = overflow_q;
    captured_d = captured_q;
    if (capture && !fifo_push_ok) overflow_d = 1'b1;
    if (fifo_push_ok && (captured_q != '1)) captured_d = captured_q + 1'b1;
    if (bus.CLEAR) begin
      overflow_d = 1'b0;
      captured_d = '0;
    end
  end

  // Display FSM
  disp_state_e       state_q, state_d;
  entry_t            disp_q, disp_d;
  show_idx_e         idx_q, idx_d;
  logic [DCNT_W-1:0] dwell_q, dwell_d;
  logic [7:0]        leds_q, leds_d;
  logic [2:0]        show_idx_q, show_idx_d;

  // NOTE: every variable driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    disp_d   = disp_q;
    idx_d    = idx_q;
    dwell_d  = dwell_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        fifo_pop = 1'b1;
        disp_d   = head;
        idx_d    = first_idx(head.mode_fp);
        dwell_d  = '0;
        state_d  = ST_SHOW;
      end
      ST_SHOW: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (idx_q == IDX_FLAGS) begin
            state_d = fifo_empty ? ST_HOLD : ST_LOAD;
          end else begin
            idx_d = show_idx_e'(idx_q + 3'd1);
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // LEDs are computed from next-state values so the output is a true flop.
  always_comb begin
    leds_d     = '0;
    show_idx_d = IDX_NONE;
    case (state_d)
      ST_SHOW: begin
        leds_d     = select_byte(disp_d, idx_d);
        show_idx_d = idx_d;
      end
      ST_HOLD: leds_d = select_byte(disp_d, first_idx(disp_d.mode_fp));
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      captured_q <= '0;
      state_q    <= ST_IDLE;
      disp_q     <= '0;
      idx_q      <= IDX_NONE;
      dwell_q    <= '0;
      leds_q     <= '0;
      show_idx_q <= IDX_NONE;
    end else begin
      valid_q    <= bus.VALID_OUT;
      overflow_q <= overflow_d;
      captured_q <= captured_d;
      state_q    <= state_d;
      disp_q     <= disp_d;
      idx_q      <= idx_d;
      dwell_q    <= dwell_d;
      leds_q     <= leds_d;
      show_idx_q <= show_idx_d;
    end
  end

  assign bus.LEDS     = leds_q;
  assign bus.SHOW_IDX = show_idx_q;
  assign bus.EMPTY    = fifo_empty;
  assign bus.FULL     = fifo_full;
  assign bus.OVERFLOW = overflow_q;
  assign bus.CAPTURED = captured_q;

endmodule

// File: tb/tb_strokie_result_sink.sv
// Self-checking bench for strokie_result_sink: table-driven single/half vectors
// plus burst, overflow, push/pop-while-full and reset sequences, with a byte scoreboard.
module tb_strokie_result_sink;
  import strokie_pkg::*;

  localparam int DEPTH = 4;
  localparam int DWELL = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  strokie_result_sink_if #(.CNT_W(CNT_W)) bus ();

  strokie_result_sink #(
    .DEPTH (DEPTH),
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [10:0] exp_q[$];  // {SHOW_IDX, LEDS}, one record per display cycle

  typedef struct {
    logic            mode;
    logic [31:0]     result;
    logic [4:0]      flags;
    int              valid_len;
    logic [2:0]      first;
    logic [4:0][7:0] bytes;  // bytes[4] is shown first
    int              n_bytes;
    logic [7:0]      hold;
    logic [7:0]      cap;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every cycle the DUT shows a byte, it must match the next expected record.
  always @(negedge clk) begin : monitor
    logic [10:0] e;
    if (!rst && bus.SHOW_IDX != 3'd7) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_byte: got idx %0d leds %0h, expected nothing (t=%0t)",
                 bus.SHOW_IDX, bus.LEDS, $time);
      end else begin
        e = exp_q.pop_front();
        check("show_byte", 32'({bus.SHOW_IDX, bus.LEDS}), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_entry(input logic mode, input logic [31:0] res, input logic [4:0] fl);
    logic [7:0] b;
    int first;
    first = mode ? 0 : 2;
    for (int ix = first; ix <= 4; ix++) begin
      case (ix)
        0:       b = res[31:24];
        1:       b = res[23:16];
        2:       b = res[15:8];
        3:       b = res[7:0];
        default: b = {3'b000, fl};
      endcase
      repeat (DWELL) exp_q.push_back({3'(ix), b});
    end
  endtask

  task automatic pulse(input logic mode, input logic [31:0] res, input logic [4:0] fl, input int len);
    bus.MODE_FP   = mode;
    bus.RESULT    = res;
    bus.FLAGS     = fl;
    bus.VALID_OUT = 1'b1;
    repeat (len) @(negedge clk);
    bus.VALID_OUT = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_pulse();
    bus.CLEAR = 1'b1;
    @(negedge clk);
    bus.CLEAR = 1'b0;
  endtask

  task automatic wait_idx(input logic [2:0] target, input string name);
    int cyc;
    cyc = 0;
    while (bus.SHOW_IDX !== target && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_reached"}, 32'(cyc < 200), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while (!(exp_q.size() == 0 && bus.SHOW_IDX == 3'd7) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_drained"}, 32'(cyc < 3000), 32'd1);
  endtask

  initial begin
    logic [2:0]  ix;
    logic [31:0] res;
    bus.RESULT    = '0;
    bus.VALID_OUT = 1'b0;
    bus.FLAGS     = '0;
    bus.MODE_FP   = 1'b0;
    bus.CLEAR     = 1'b0;

    vecs[0] = '{1'b1, 32'hA1B2_C3D4, 5'b00101, 1,  3'd0, {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h05}, 5, 8'hA1, 8'd1};
    vecs[1] = '{1'b0, 32'h0000_56B0, 5'b00000, 1,  3'd2, {8'h56, 8'hB0, 8'h00, 8'h00, 8'h00}, 3, 8'h56, 8'd2};
    vecs[2] = '{1'b1, 32'h1234_5678, 5'b11111, 10, 3'd0, {8'h12, 8'h34, 8'h56, 8'h78, 8'h1F}, 5, 8'h12, 8'd3};
    vecs[3] = '{1'b0, 32'hDEAD_BEEF, 5'b10000, 1,  3'd2, {8'hBE, 8'hEF, 8'h10, 8'h00, 8'h00}, 3, 8'hBE, 8'd4};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_leds",     32'(bus.LEDS),     32'h00);
    check("rst_show_idx", 32'(bus.SHOW_IDX), 32'd7);
    check("rst_empty",    32'(bus.EMPTY),    32'd1);
    check("rst_full",     32'(bus.FULL),     32'd0);
    check("rst_overflow", 32'(bus.OVERFLOW), 32'd0);
    check("rst_captured", 32'(bus.CAPTURED), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single/half results, including a long VALID_OUT level
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < vecs[v].n_bytes; k++) begin
        ix = vecs[v].first + 3'(k);
        repeat (DWELL) exp_q.push_back({ix, vecs[v].bytes[4-k]});
      end
      pulse(vecs[v].mode, vecs[v].result, vecs[v].flags, vecs[v].valid_len);
      wait_drain("vec");
      check("vec_hold_leds", 32'(bus.LEDS),     32'(vecs[v].hold));
      check("vec_hold_idx",  32'(bus.SHOW_IDX), 32'd7);
      check("vec_captured",  32'(bus.CAPTURED), 32'(vecs[v].cap));
      check("vec_empty",     32'(bus.EMPTY),    32'd1);
    end

    clear_pulse();
    check("clear_captured", 32'(bus.CAPTURED), 32'd0);
    check("clear_overflow", 32'(bus.OVERFLOW), 32'd0);

    // Burst of 6 during the first display: 1 popped, 4 queued, 1 dropped
    for (int i = 0; i < 5; i++) begin
      res = 32'h1020_3040 + 32'h0101_0101 * 32'(i);
      expect_entry((i % 2) == 0, res, 5'(i + 1));
    end
    pulse(1'b1, 32'h1020_3040, 5'd1, 1);
    wait_idx(3'd0, "burst_first");
    for (int i = 1; i < 5; i++) begin
      res = 32'h1020_3040 + 32'h0101_0101 * 32'(i);
      pulse((i % 2) == 0, res, 5'(i + 1), 1);
    end
    pulse(1'b1, 32'hEEEE_EEEE, 5'd31, 1);
    check("burst_full",     32'(bus.FULL),     32'd1);
    check("burst_overflow", 32'(bus.OVERFLOW), 32'd1);
    check("burst_captured", 32'(bus.CAPTURED), 32'd5);
    wait_drain("burst");
    check("burst_hold_leds",     32'(bus.LEDS),     32'h14);
    check("burst_overflow_kept", 32'(bus.OVERFLOW), 32'd1);
    check("burst_empty",         32'(bus.EMPTY),    32'd1);
    clear_pulse();
    check("burst_clear_overflow", 32'(bus.OVERFLOW), 32'd0);
    check("burst_clear_captured", 32'(bus.CAPTURED), 32'd0);

    // Push and pop in the same cycle while FULL
    for (int i = 0; i < 6; i++) begin
      res = 32'hA0B0_C0D0 + 32'h0101_0101 * 32'(i);
      expect_entry((i % 2) == 1, res, 5'(i + 8));
    end
    pulse(1'b0, 32'hA0B0_C0D0, 5'd8, 1);
    wait_idx(3'd2, "pp_first");
    for (int i = 1; i < 5; i++) begin
      res = 32'hA0B0_C0D0 + 32'h0101_0101 * 32'(i);
      pulse((i % 2) == 1, res, 5'(i + 8), 1);
    end
    check("pp_full_before", 32'(bus.FULL), 32'd1);
    wait_idx(3'd7, "pp_load");
    res = 32'hA0B0_C0D0 + 32'h0101_0101 * 32'd5;
    bus.MODE_FP   = 1'b1;
    bus.RESULT    = res;
    bus.FLAGS     = 5'd13;
    bus.VALID_OUT = 1'b1;
    @(negedge clk);
    bus.VALID_OUT = 1'b0;
    check("pp_full_after", 32'(bus.FULL),     32'd1);
    check("pp_overflow",   32'(bus.OVERFLOW), 32'd0);
    check("pp_captured",   32'(bus.CAPTURED), 32'd6);
    wait_drain("pp");
    check("pp_hold_leds", 32'(bus.LEDS), 32'hA5);

    // Reset in the middle of byte 2
    expect_entry(1'b1, 32'hCAFE_F00D, 5'd3);
    pulse(1'b1, 32'hCAFE_F00D, 5'd3, 1);
    wait_idx(3'd2, "mid_byte2");
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_leds",     32'(bus.LEDS),     32'h00);
    check("midrst_show_idx", 32'(bus.SHOW_IDX), 32'd7);
    check("midrst_empty",    32'(bus.EMPTY),    32'd1);
    check("midrst_captured", 32'(bus.CAPTURED), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    expect_entry(1'b0, 32'h0000_9A7C, 5'b01010);
    pulse(1'b0, 32'h0000_9A7C, 5'b01010, 1);
    wait_drain("post_rst");
    check("post_rst_hold",     32'(bus.LEDS),     32'h9A);
    check("post_rst_captured", 32'(bus.CAPTURED), 32'd1);

    // VALID_OUT already high when reset releases counts as one edge
    rst = 1'b1;
    bus.MODE_FP   = 1'b1;
    bus.RESULT    = 32'h55AA_33CC;
    bus.FLAGS     = 5'd0;
    bus.VALID_OUT = 1'b1;
    expect_entry(1'b1, 32'h55AA_33CC, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus.VALID_OUT = 1'b0;
    wait_drain("valid_at_release");
    check("release_captured", 32'(bus.CAPTURED), 32'd1);
    check("release_hold",     32'(bus.LEDS),     32'h55);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/strokie_result_sink.md
Name: strokie_result_sink

Overview:
- Receiving end of the strokie FP unit's result interface (RESULT / VALID_OUT / FLAGS).
- Captures each completed result, with its flags and precision mode, into a small FIFO.
- Replays each captured entry byte-by-byte on the 8 board LEDs, holding each byte for a programmable dwell time, so every result of a burst is observable on hardware.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DWELL, 50_000_000, cycles each byte is shown; minimum 1.
- CNT_W, 8, width of the captured-result counter.

Ports:
- CLK  input  1  system clock (one clock domain).
- RESET  input  1  synchronous, active-high reset.
- RESULT  input  32  strokie result; half-precision results occupy bits [15:0].
- VALID_OUT  input  1  strokie result-valid; may be held high for more than one cycle.
- FLAGS  input  5  strokie exception flags, valid with VALID_OUT.
- MODE_FP  input  1  precision of the current result: 0 = half, 1 = single.
- CLEAR  input  1  one-cycle pulse; clears OVERFLOW and CAPTURED (FIFO contents untouched).
- LEDS  output  8  byte currently displayed.
- SHOW_IDX  output  3  index of the displayed byte: 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0], 4 = flags byte, 7 = idle/hold.
- EMPTY  output  1  FIFO empty.
- FULL  output  1  FIFO full.
- OVERFLOW  output  1  sticky; set when a result was dropped because the FIFO was full.
- CAPTURED  output  CNT_W  results accepted; saturates at all-ones.

Behaviour:
- Reset values: LEDS = 0, SHOW_IDX = 7, EMPTY = 1, FULL = 0, OVERFLOW = 0, CAPTURED = 0; FIFO pointers = 0; FSM in IDLE.
- Reset asserted mid-display aborts the display immediately, with no residual byte.
- Capture event: rising edge of VALID_OUT, i.e. VALID_OUT = 1 and the registered previous VALID_OUT = 0.
  - A level held high for N cycles gives exactly one capture.
  - The previous-VALID_OUT register resets to 0, so VALID_OUT already high when reset releases counts as an edge on the first cycle.
- On a capture event, the 38-bit entry {MODE_FP, FLAGS, RESULT} is pushed. The entry is visible to the display FSM the cycle after the push.
- Push while FULL and no pop in the same cycle: the entry is dropped, OVERFLOW is set, and CAPTURED is unchanged.
- Simultaneous push and pop while FULL: both happen, no drop.
- CAPTURED increments on every accepted push and saturates.
- CLEAR and an accepted push in the same cycle: CLEAR wins, so CAPTURED = 0.
- Display FSM states: IDLE, LOAD, SHOW, HOLD.
  - IDLE: LEDS = 0, SHOW_IDX = 7. Goes to LOAD when the FIFO is non-empty.
  - LOAD (1 cycle): pop the head into the display register; set the byte index to the first byte (0 for single, 2 for half); clear the dwell counter; go to SHOW.
  - SHOW: LEDS = the selected byte; the flags byte is {3'b000, FLAGS}. SHOW_IDX = the index. Each byte is held exactly DWELL cycles, then the index advances.
    - Single sequence: 0, 1, 2, 3, 4.
    - Half sequence: 2, 3, 4.
    - After index 4 completes: go to LOAD if the FIFO is non-empty, else HOLD.
  - HOLD: LEDS = the first byte of the last entry (RESULT[31:24] for single, RESULT[15:8] for half), SHOW_IDX = 7. Goes to LOAD as soon as the FIFO is non-empty.
- Latency: from the capture edge to the first byte on LEDS is 3 cycles in IDLE or HOLD (push, LOAD, SHOW).
- The dwell counter width is clog2(DWELL+1). DWELL = 1 means each byte shows for one cycle.
- Registered outputs only; no combinational path from any input to LEDS.

Decomposition:
- Shared package strokie_pkg:
  - display state encoding;
  - SHOW_IDX codes (IDX_B3 = 0 … IDX_FLAGS = 4, IDX_NONE = 7);
  - FLAGS width (5);
  - entry width (38);
  - MODE_FP encodings (FP_HALF = 0, FP_SINGLE = 1).
- One sub-module, strokie_sync_fifo (parameters WIDTH and DEPTH). It is a synchronous FIFO with push, pop, full and empty, and allows push and pop in the same cycle when full.
- Edge detect, counters and the FSM stay in the top of this block.

Test Plan:
- DWELL = 4; single RESULT = 32'hA1B2_C3D4, FLAGS = 5'b00101, one VALID_OUT pulse -> LEDS = A1, B2, C3, D4, 05 for 4 cycles each, with SHOW_IDX 0..4; then HOLD with LEDS = A1, SHOW_IDX = 7; CAPTURED = 1.
- Half RESULT = 32'h0000_56B0, FLAGS = 0, MODE_FP = 0 -> LEDS = 56, B0, 00 for 4 cycles each; then hold at 56.
- VALID_OUT held high for 10 cycles with one result -> exactly one capture: CAPTURED = 1, sequence shown once.
- DEPTH = 4; 6 results on consecutive rising edges during the first display -> first popped, next 4 queued, 1 dropped; OVERFLOW = 1, CAPTURED = 5; all 5 shown in order. Then CLEAR -> OVERFLOW = 0, CAPTURED = 0.
- Push and pop in the same cycle while FULL -> no drop, OVERFLOW stays 0.
- RESET asserted in the middle of byte 2 -> next cycle LEDS = 0, SHOW_IDX = 7, EMPTY = 1, CAPTURED = 0; a new pulse after release displays normally.
